// File: rtl/controlador_estabelecidos_pkg.sv
// rtl/controlador_estabelecidos_pkg.sv - shared constants for the established-node controller
package controlador_estabelecidos_pkg;

    // Neighbour slots per request; tied to the memory's 8 neighbour read ports.
    localparam int NUM_VIZ = 8;

    typedef logic [1:0] estado_t;

    localparam estado_t ST_IDLE  = 2'd0;
    localparam estado_t ST_CHECK = 2'd1;
    localparam estado_t ST_EMIT  = 2'd2;
    localparam estado_t ST_MARK  = 2'd3;

    // Lowest bit of neighbour slot k inside the packed neighbour bus.
    function automatic int viz_lsb(input int k, input int aw);
        return k * aw;
    endfunction

endpackage

// File: rtl/controlador_estabelecidos_seletor_prioridade.sv
// rtl/controlador_estabelecidos_seletor_prioridade.sv - lowest-set-bit finder over the pending mask
module seletor_prioridade (
    input  logic [7:0] pend_i,
    output logic [2:0] idx_o,
    output logic [7:0] clr_o,
    output logic       unico_o,
    output logic       algum_o
);

    // Scan from the top so the last hit written is the lowest set bit.
    always_comb begin
        idx_o = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pend_i[k]) begin
                idx_o = 3'(k);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit as a one-hot mask.
    assign clr_o   = pend_i & (~pend_i + 8'd1);
    assign algum_o = |pend_i;
    // Clearing the lowest bit leaves nothing only when one bit was set.
    assign unico_o = algum_o && ((pend_i & (pend_i - 8'd1)) == 8'd0);

endmodule

// File: rtl/controlador_estabelecidos.sv
// rtl/controlador_estabelecidos.sv - filters and streams unestablished neighbours, then marks the node
module controlador_estabelecidos
    import controlador_estabelecidos_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_VIZ    = controlador_estabelecidos_pkg::NUM_VIZ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid_in,
    output logic                          req_ready_out,
    input  logic [ADDR_WIDTH-1:0]         no_atual_in,
    input  logic [NUM_VIZ*ADDR_WIDTH-1:0] vizinhos_in,
    input  logic [NUM_VIZ-1:0]            vizinhos_valid_in,
    output logic [ADDR_WIDTH-1:0]         read_addr0_out,
    output logic [ADDR_WIDTH-1:0]         read_addr1_out,
    output logic [ADDR_WIDTH-1:0]         read_addr2_out,
    output logic [ADDR_WIDTH-1:0]         read_addr3_out,
    output logic [ADDR_WIDTH-1:0]         read_addr4_out,
    output logic [ADDR_WIDTH-1:0]         read_addr5_out,
    output logic [ADDR_WIDTH-1:0]         read_addr6_out,
    output logic [ADDR_WIDTH-1:0]         read_addr7_out,
    output logic [ADDR_WIDTH-1:0]         read_addr8_out,
    input  logic                          read_data0_in,
    input  logic                          read_data1_in,
    input  logic                          read_data2_in,
    input  logic                          read_data3_in,
    input  logic                          read_data4_in,
    input  logic                          read_data5_in,
    input  logic                          read_data6_in,
    input  logic                          read_data7_in,
    input  logic                          read_data8_in,
    output logic                          write_en_out,
    output logic [ADDR_WIDTH-1:0]         write_addr_out,
    output logic                          write_data_out,
    output logic                          viz_valid_out,
    input  logic                          viz_ready_in,
    output logic [ADDR_WIDTH-1:0]         viz_addr_out,
    output logic                          viz_last_out,
    output logic                          done_out,
    output logic                          ja_estabelecido_out
);

    estado_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0] no_atual_q;
    logic [ADDR_WIDTH-1:0] viz_q [NUM_VIZ];
    logic [NUM_VIZ-1:0]    valid_q;
    logic [NUM_VIZ-1:0]    pend_q, pend_d;
    logic                  ja_q;

    logic [NUM_VIZ-1:0]    rd_viz;
    logic [NUM_VIZ-1:0]    pend_chk;
    logic [2:0]            sel_idx;
    logic [7:0]            sel_clr;
    logic                  sel_unico;
    logic                  sel_algum;

    assign rd_viz = {read_data8_in, read_data7_in, read_data6_in, read_data5_in,
                     read_data4_in, read_data3_in, read_data2_in, read_data1_in};

    // Read ports are fed from the latches so the data is stable across CHECK.
    assign read_addr0_out = no_atual_q;
    assign read_addr1_out = viz_q[0];
    assign read_addr2_out = viz_q[1];
    assign read_addr3_out = viz_q[2];
    assign read_addr4_out = viz_q[3];
    assign read_addr5_out = viz_q[4];
    assign read_addr6_out = viz_q[5];
    assign read_addr7_out = viz_q[6];
    assign read_addr8_out = viz_q[7];

    // Only a 1 is ever written: this block only marks nodes established.
    assign write_data_out = 1'b1;
    assign write_addr_out = no_atual_q;

    // Surviving neighbours: valid, not yet established, not a self-loop.
    always_comb begin
        pend_chk = '0;
        for (int k = 0; k < NUM_VIZ; k++) begin
            pend_chk[k] = valid_q[k] & ~rd_viz[k] & (viz_q[k] != no_atual_q);
        end
    end

    seletor_prioridade u_seletor (
        .pend_i  (pend_q),
        .idx_o   (sel_idx),
        .clr_o   (sel_clr),
        .unico_o (sel_unico),
        .algum_o (sel_algum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next pending mask.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_in) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (read_data0_in) begin
                    state_d = ST_IDLE;
                    pend_d  = '0;
                end else begin
                    pend_d  = pend_chk;
                    state_d = (|pend_chk) ? ST_EMIT : ST_MARK;
                end
            end
            ST_EMIT: begin
                if (viz_ready_in && sel_algum) begin
                    pend_d = pend_q & ~sel_clr;
                    if (sel_unico) begin
                        state_d = ST_MARK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latches, pending mask and the already-established pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            no_atual_q <= '0;
            valid_q    <= '0;
            pend_q     <= '0;
            ja_q       <= 1'b0;
            for (int k = 0; k < NUM_VIZ; k++) begin
                viz_q[k] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ja_q   <= (state_q == ST_CHECK) && read_data0_in;
            if (state_q == ST_IDLE && req_valid_in) begin
                no_atual_q <= no_atual_in;
                valid_q    <= vizinhos_valid_in;
                for (int k = 0; k < NUM_VIZ; k++) begin
                    viz_q[k] <= vizinhos_in[viz_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
                end
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        req_ready_out       = (state_q == ST_IDLE);
        viz_valid_out       = (state_q == ST_EMIT);
        viz_last_out        = (state_q == ST_EMIT) && sel_unico;
        viz_addr_out        = (state_q == ST_EMIT) ? viz_q[sel_idx] : '0;
        write_en_out        = (state_q == ST_MARK);
        done_out            = (state_q == ST_MARK);
        ja_estabelecido_out = ja_q;
    end

endmodule

// File: tb/tb_controlador_estabelecidos.sv
// tb/tb_controlador_estabelecidos.sv - self-checking bench for controlador_estabelecidos
module tb_controlador_estabelecidos;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [7:0]  no_atual_in;
    logic [63:0] vizinhos_in;
    logic [7:0]  vizinhos_valid_in;
    logic [7:0]  ra0, ra1, ra2, ra3, ra4, ra5, ra6, ra7, ra8;
    logic        rd0, rd1, rd2, rd3, rd4, rd5, rd6, rd7, rd8;
    logic        write_en_out;
    logic [7:0]  write_addr_out;
    logic        write_data_out;
    logic        viz_valid_out;
    logic        viz_ready_in;
    logic [7:0]  viz_addr_out;
    logic        viz_last_out;
    logic        done_out;
    logic        ja_estabelecido_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    controlador_estabelecidos #(.ADDR_WIDTH(8), .NUM_VIZ(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .no_atual_in(no_atual_in), .vizinhos_in(vizinhos_in),
        .vizinhos_valid_in(vizinhos_valid_in),
        .read_addr0_out(ra0), .read_addr1_out(ra1), .read_addr2_out(ra2),
        .read_addr3_out(ra3), .read_addr4_out(ra4), .read_addr5_out(ra5),
        .read_addr6_out(ra6), .read_addr7_out(ra7), .read_addr8_out(ra8),
        .read_data0_in(rd0), .read_data1_in(rd1), .read_data2_in(rd2),
        .read_data3_in(rd3), .read_data4_in(rd4), .read_data5_in(rd5),
        .read_data6_in(rd6), .read_data7_in(rd7), .read_data8_in(rd8),
        .write_en_out(write_en_out), .write_addr_out(write_addr_out),
        .write_data_out(write_data_out),
        .viz_valid_out(viz_valid_out), .viz_ready_in(viz_ready_in),
        .viz_addr_out(viz_addr_out), .viz_last_out(viz_last_out),
        .done_out(done_out), .ja_estabelecido_out(ja_estabelecido_out)
    );

    // Established memory: combinational reads, write on the rising edge.
    logic       mem [256];
    logic       mem_clr = 1'b0;
    logic       preset_en = 1'b0;
    logic [7:0] preset_addr = 8'd0;

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign rd3 = mem[ra3];
    assign rd4 = mem[ra4];
    assign rd5 = mem[ra5];
    assign rd6 = mem[ra6];
    assign rd7 = mem[ra7];
    assign rd8 = mem[ra8];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 1'b0;
        end else begin
            if (preset_en) mem[preset_addr] <= 1'b1;
            if (write_en_out) mem[write_addr_out] <= write_data_out;
        end
    end

    typedef struct {
        logic        clr;
        int          preset;
        logic [7:0]  node;
        logic [63:0] viz;
        logic [7:0]  vm;
        int          stall_at;
        int          stall_len;
        logic        exp_ja;
        int          exp_n;
        logic [63:0] exp_list;
        int          exp_mark;
    } vec_t;

    vec_t tab [8];

    logic [7:0] obs_q  [$];
    logic       last_q [$];
    int  r_mark, r_ja, r_rdy, r_wr;
    bit  r_timeout, r_hold_err, r_wa_err;
    logic r_rdy1;

    // Reference state: which nodes are established, per the marking rule.
    bit est_m [256];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {40'd0, c, b, a};
    endfunction

    task automatic mem_prep(input bit clr, input int preset);
        if (clr) begin
            mem_clr = 1'b1;
            @(posedge clk); #1;
            mem_clr = 1'b0;
        end
        if (preset >= 0) begin
            preset_en   = 1'b1;
            preset_addr = 8'(preset);
            @(posedge clk); #1;
            preset_en = 1'b0;
        end
    endtask

    // Issue one request and record what the DUT does, cycle by cycle after acceptance.
    task automatic run_req(input logic [7:0] node, input logic [63:0] viz, input logic [7:0] vm,
                           input int stall_at, input int stall_len);
        int   c, guard, stalls;
        bit   prev_stall;
        logic [7:0] held;
        obs_q.delete();
        last_q.delete();
        r_mark = -1; r_ja = -1; r_rdy = -1; r_wr = 0;
        r_timeout = 0; r_hold_err = 0; r_wa_err = 0; r_rdy1 = 1'b0;
        stalls = 0; prev_stall = 0; held = 8'd0;
        guard = 0;
        while (!req_ready_out && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid_in      = 1'b1;
        no_atual_in       = node;
        vizinhos_in       = viz;
        vizinhos_valid_in = vm;
        viz_ready_in      = 1'b1;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        c = 1;
        while (c < 64) begin
            if (c == 1) r_rdy1 = req_ready_out;
            if (ja_estabelecido_out && r_ja < 0) r_ja = c;
            if (write_en_out) begin
                r_wr++;
                if (r_mark < 0) r_mark = c;
                if (write_addr_out != node || !write_data_out || !done_out) r_wa_err = 1;
            end
            if (done_out && !write_en_out) r_wa_err = 1;
            if (req_ready_out && c > 1 && r_rdy < 0) r_rdy = c;
            if (viz_valid_out) begin
                if (prev_stall && viz_addr_out != held) r_hold_err = 1;
                if (obs_q.size() == stall_at && stalls < stall_len) begin
                    viz_ready_in = 1'b0;
                    stalls++;
                    prev_stall = 1;
                    held = viz_addr_out;
                end else begin
                    viz_ready_in = 1'b1;
                    prev_stall = 0;
                    obs_q.push_back(viz_addr_out);
                    last_q.push_back(viz_last_out);
                end
            end else begin
                viz_ready_in = 1'($urandom_range(0, 1));
            end
            if (r_rdy > 0) break;
            @(posedge clk); #1;
            c++;
        end
        if (r_rdy < 0) r_timeout = 1;
        viz_ready_in = 1'b1;
    endtask

    task automatic verify(input string nm, input logic exp_ja, input int exp_n,
                          input logic [63:0] exp_list, input int exp_mark);
        int n;
        chk({nm, ".timeout"}, int'(r_timeout), 0);
        chk({nm, ".ready_check"}, int'(r_rdy1), 0);
        chk({nm, ".ja_cycle"}, r_ja, exp_ja ? 2 : -1);
        chk({nm, ".mark_cycle"}, r_mark, exp_ja ? -1 : exp_mark);
        chk({nm, ".writes"}, r_wr, exp_ja ? 0 : 1);
        chk({nm, ".ready_back"}, r_rdy, exp_ja ? 2 : exp_mark + 1);
        chk({nm, ".count"}, obs_q.size(), exp_n);
        n = (obs_q.size() < exp_n) ? obs_q.size() : exp_n;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.addr%0d", nm, i), int'(obs_q[i]), int'(exp_list[8*i +: 8]));
            chk($sformatf("%s.last%0d", nm, i), int'(last_q[i]), (i == exp_n - 1) ? 1 : 0);
        end
        chk({nm, ".hold"}, int'(r_hold_err), 0);
        chk({nm, ".write_port"}, int'(r_wa_err), 0);
    endtask

    initial begin
        int wr;
        rst_n = 1'b0;
        req_valid_in = 1'b0;
        no_atual_in = 8'd0;
        vizinhos_in = 64'd0;
        vizinhos_valid_in = 8'd0;
        viz_ready_in = 1'b1;

        tab[0] = '{1, -1, 8'd5, pack3(9, 12, 3), 8'h07, 8, 0, 0, 3, pack3(9, 12, 3), 5};
        tab[1] = '{1, 12, 8'd5, pack3(9, 12, 3), 8'h07, 8, 0, 0, 2, pack3(9, 3, 0), 4};
        tab[2] = '{0, -1, 8'd5, pack3(9, 12, 3), 8'h07, 8, 0, 1, 0, 64'd0, -1};
        tab[3] = '{0, -1, 8'd7, pack3(7, 8, 0), 8'h01, 8, 0, 0, 0, 64'd0, 2};
        tab[4] = '{0, -1, 8'd8, pack3(1, 2, 3), 8'h00, 8, 0, 0, 0, 64'd0, 2};
        tab[5] = '{1, -1, 8'd20, pack3(30, 31, 32), 8'h07, 1, 4, 0, 3, pack3(30, 31, 32), 9};
        tab[6] = '{1, -1, 8'd40, {8'd67, 8'd66, 8'd65, 8'd64, 8'd60, 8'd62, 8'd61, 8'd60}, 8'hFF,
                   8, 0, 0, 8, {8'd67, 8'd66, 8'd65, 8'd64, 8'd60, 8'd62, 8'd61, 8'd60}, 10};
        tab[7] = '{1, -1, 8'd100, {8'd107, 8'd1, 8'd105, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 8'hA0,
                   0, 2, 0, 2, {48'd0, 8'd107, 8'd105}, 6};

        mem_prep(1, -1);
        @(posedge clk); #1;
        chk("reset.req_ready", int'(req_ready_out), 1);
        chk("reset.viz_valid", int'(viz_valid_out), 0);
        chk("reset.viz_last", int'(viz_last_out), 0);
        chk("reset.write_en", int'(write_en_out), 0);
        chk("reset.done", int'(done_out), 0);
        chk("reset.ja", int'(ja_estabelecido_out), 0);
        chk("reset.read_addr0", int'(ra0), 0);
        chk("reset.read_addr8", int'(ra8), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) begin
            mem_prep(tab[t].clr, tab[t].preset);
            run_req(tab[t].node, tab[t].viz, tab[t].vm, tab[t].stall_at, tab[t].stall_len);
            verify($sformatf("tab%0d", t), tab[t].exp_ja, tab[t].exp_n, tab[t].exp_list, tab[t].exp_mark);
        end

        // Reset asserted while a neighbour is being offered.
        mem_prep(1, -1);
        no_atual_in = 8'd90;
        vizinhos_in = pack3(91, 92, 93);
        vizinhos_valid_in = 8'h07;
        req_valid_in = 1'b1;
        viz_ready_in = 1'b0;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        @(posedge clk); #1;
        chk("rst.emit_valid", int'(viz_valid_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.async_valid", int'(viz_valid_out), 0);
        chk("rst.async_ready", int'(req_ready_out), 1);
        chk("rst.async_write", int'(write_en_out), 0);
        chk("rst.async_addr1", int'(ra1), 0);
        req_valid_in = 1'b1;
        wr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (write_en_out || viz_valid_out) wr++;
        end
        #2 rst_n = 1'b1;
        req_valid_in = 1'b0;
        viz_ready_in = 1'b1;
        @(posedge clk); #1;
        if (write_en_out || viz_valid_out) wr++;
        chk("rst.no_activity", wr, 0);
        chk("rst.ready_after", int'(req_ready_out), 1);
        chk("rst.mem90_unmarked", int'(mem[90]), 0);
        run_req(8'd90, pack3(91, 92, 93), 8'h07, 8, 0);
        verify("rst.resume", 1'b0, 3, pack3(91, 92, 93), 5);

        // Randomized requests against the reference model.
        mem_prep(1, -1);
        for (int i = 0; i < 256; i++) est_m[i] = 0;
        for (int r = 0; r < 40; r++) begin
            logic [7:0]  node, vm;
            logic [63:0] viz, exp_list;
            int          n, sa, sl, mark;
            logic        ja;
            node = 8'($urandom_range(0, 15));
            vm   = 8'($urandom);
            for (int k = 0; k < 8; k++) viz[8*k +: 8] = 8'($urandom_range(0, 15));
            sa = $urandom_range(0, 7);
            sl = $urandom_range(0, 3);
            exp_list = 64'd0;
            n = 0;
            ja = est_m[node];
            if (!ja) begin
                for (int k = 0; k < 8; k++) begin
                    if (vm[k] && !est_m[viz[8*k +: 8]] && viz[8*k +: 8] != node) begin
                        exp_list[8*n +: 8] = viz[8*k +: 8];
                        n++;
                    end
                end
                est_m[node] = 1;
            end
            mark = 2 + n + ((sa < n) ? sl : 0);
            run_req(node, viz, vm, sa, sl);
            verify($sformatf("rnd%0d", r), ja, n, exp_list, mark);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
